mem_subsystem_ctrl: RTL and testbench

Parametrised memory subsystem for the 16-bit RISC single-cycle platform. It sits between `cpu_core`'s data port and local storage. It replaces the fixed zero-latency data-memory hookup with a request/ready handshake, a configurable number of wait states, and a memory-mapped I/O register bank in the top of the address space. Instruction fetch is outside this block's scope.

---
 rtl/mem_sys_pkg.sv | 19 +
 rtl/sp_ram_sync.sv | 27 ++
 rtl/mem_subsystem_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_subsystem_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory subsystem: FSM state encoding,
// wait-counter width and the I/O window base address helper.
package mem_sys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Wait counter holds WAIT_STATES, which is limited to 0..15.
  localparam int WAIT_CNT_W = 4;

  // First address of the I/O window; everything below it is RAM.
  function automatic int io_base(input int addr_w, input int num_io);
    return (1 << addr_w) - num_io;
  endfunction

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port RAM: synchronous write, registered read, no reset on the
// array so it maps onto plain memory macros or distributed RAM.
module sp_ram_sync #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 60,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write stores the word; read captures the addressed word into rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_subsystem_ctrl.sv
// Data-side memory subsystem: request/ready handshake with programmable
// wait states, RAM in the low address range and an I/O register bank in
// the top NUM_IO words.
module mem_subsystem_ctrl
  import mem_sys_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int NUM_IO      = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_wr,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     busy,
  output logic [NUM_IO*DATA_W-1:0] io_out
);

  localparam int RAM_DEPTH = io_base(ADDR_W, NUM_IO);
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] IO_BASE = RAM_DEPTH[ADDR_W-1:0];

  if (NUM_IO < 1 || NUM_IO >= (1 << ADDR_W)) begin : g_bad_num_io
    $error("mem_subsystem_ctrl: NUM_IO out of range");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("mem_subsystem_ctrl: WAIT_STATES out of range");
  end

  mem_state_t              state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic                    lat_wr;
  logic [ADDR_W-1:0]       lat_addr;
  logic [DATA_W-1:0]       lat_wdata;
  logic [DATA_W-1:0]       io_q [NUM_IO];
  logic [DATA_W-1:0]       io_rd_q;
  logic                    ready_q;
  logic                    busy_q;

  logic                    is_io;
  logic [ADDR_W-1:0]       io_idx;
  logic                    execute;
  logic [DATA_W-1:0]       io_rd_val;
  logic                    ram_we;
  logic                    ram_re;
  logic [DATA_W-1:0]       ram_rdata;

  // Decode always works on the latched address, never on the live bus.
  assign is_io   = (lat_addr >= IO_BASE);
  assign io_idx  = lat_addr - IO_BASE;
  assign execute = (state == ST_WAIT) && (cnt == '0);
  assign ram_we  = execute && lat_wr && !is_io;
  assign ram_re  = execute && !lat_wr && !is_io;

  // Select the addressed I/O register for a read.
  always_comb begin
    io_rd_val = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (io_idx == ADDR_W'(k)) begin
        io_rd_val = io_q[k];
      end
    end
  end

  // Handshake FSM, request latch, wait counter and I/O register bank.
  // | state   | meaning                                             |
  // | ST_IDLE | no access pending, accepting requests               |
  // | ST_WAIT | access latched, counting down wait states           |
  // | ST_DONE | access completed, ready pulse, accepting requests   |
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      io_rd_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < NUM_IO; k++) begin
        io_q[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          ready_q <= 1'b0;
          if (cpu_req) begin
            lat_wr    <= cpu_wr;
            lat_addr  <= cpu_addr;
            lat_wdata <= cpu_wdata;
            cnt       <= WAIT_CNT_W'(WAIT_STATES);
            state     <= ST_WAIT;
            busy_q    <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          // New requests arriving here are dropped; the CPU stalls on busy.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state   <= ST_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            if (lat_wr && is_io) begin
              for (int k = 0; k < NUM_IO; k++) begin
                if (io_idx == ADDR_W'(k)) begin
                  io_q[k] <= lat_wdata;
                end
              end
            end
            if (!lat_wr) begin
              io_rd_q <= io_rd_val;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sp_ram_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (lat_addr[RAM_AW-1:0]),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  // Read data is only driven during a read's ready cycle; zero otherwise.
  assign cpu_rdata = (ready_q && !lat_wr) ? (is_io ? io_rd_q : ram_rdata) : '0;
  assign cpu_ready = ready_q;
  assign busy      = busy_q;

  for (genvar k = 0; k < NUM_IO; k++) begin : g_io_out
    assign io_out[k*DATA_W +: DATA_W] = io_q[k];
  end

endmodule

// File: tb/tb_mem_subsystem_ctrl.sv
// Bench for mem_subsystem_ctrl: two instances (WAIT_STATES=0 and 1),
// directed scenarios plus randomized accesses against an array model.
module tb_mem_subsystem_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int NIO = 4;
  localparam int IOB = 60;

  logic clk = 1'b0;
  logic rst;
  logic            req   [2];
  logic            wr    [2];
  logic [AW-1:0]   addr  [2];
  logic [DW-1:0]   wdata [2];
  logic [DW-1:0]   rdata [2];
  logic            ready [2];
  logic            busy  [2];
  logic [NIO*DW-1:0] io_out [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance index equals its WAIT_STATES value.
  mem_subsystem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_IO(NIO), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .cpu_req(req[0]), .cpu_wr(wr[0]), .cpu_addr(addr[0]),
    .cpu_wdata(wdata[0]), .cpu_rdata(rdata[0]), .cpu_ready(ready[0]),
    .busy(busy[0]), .io_out(io_out[0]));

  mem_subsystem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_IO(NIO), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_req(req[1]), .cpu_wr(wr[1]), .cpu_addr(addr[1]),
    .cpu_wdata(wdata[1]), .cpu_rdata(rdata[1]), .cpu_ready(ready[1]),
    .busy(busy[1]), .io_out(io_out[1]));

  // Reference model: word arrays, RAM validity flags, I/O register values.
  logic [DW-1:0] mem_m [2][64];
  bit            mem_v [2][64];
  logic [DW-1:0] io_m  [2][NIO];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] io_exp(input int d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NIO; k++) r[k*DW +: DW] = io_m[d][k];
    return r;
  endfunction

  task automatic clear_io_model();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NIO; k++) io_m[d][k] = '0;
  endtask

  // One complete access; called and returns at a falling edge. When hold is
  // set the request line stays high with random junk while the access waits.
  task automatic do_access(input int d, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input bit hold,
                           output logic [DW-1:0] rd);
    int n;
    bit got;
    rd = '0;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (ready[d]) begin
        got = 1'b1;
      end else begin
        if (n == 0) check("busy_in_wait", busy[d], 1);
        if (hold) begin
          req[d] = 1'b1; wr[d] = 1'($urandom);
          addr[d] = AW'($urandom); wdata[d] = DW'($urandom);
        end else begin
          req[d] = 1'b0;
        end
        @(posedge clk);
        n++;
      end
    end
    req[d] = 1'b0;
    check("ready_seen", got, 1);
    if (!got) return;
    check("latency", n, d + 1);
    check("busy_in_done", busy[d], 0);
    rd = rdata[d];
    if (w) begin
      check("wr_rdata_zero", rdata[d], 0);
      if (a >= IOB) io_m[d][a - IOB] = wd;
      else begin
        mem_m[d][a] = wd;
        mem_v[d][a] = 1'b1;
      end
      check("io_out_after_wr", io_out[d], io_exp(d));
    end else if (a >= IOB) begin
      check("rd_io", rdata[d], io_m[d][a - IOB]);
    end else if (mem_v[d][a]) begin
      check("rd_ram", rdata[d], mem_m[d][a]);
    end
  endtask

  task automatic no_ready(input int d, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("no_extra_ready", ready[d], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    int t0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      for (int i = 0; i < 64; i++) mem_v[d][i] = 1'b0;
    end
    clear_io_model();
    #1;
    check("rst_ready", ready[1], 0);
    check("rst_busy", busy[1], 0);
    check("rst_rdata", rdata[1], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_io0", io_out[0], 0);
    check("post_rst_io1", io_out[1], 0);
    check("post_rst_busy0", busy[0], 0);

    // RAM write then read, WAIT_STATES=1.
    do_access(1, 1'b1, 6'd5, 16'hBEEF, 1'b0, rd);
    do_access(1, 1'b0, 6'd5, 16'h0000, 1'b0, rd);
    check("ram_rd_beef", rd, 16'hBEEF);

    // I/O map: address 61 is register 1.
    do_access(1, 1'b1, 6'd61, 16'h00A5, 1'b0, rd);
    check("io_reg1", io_out[1][31:16], 16'h00A5);
    check("io_others", {io_out[1][63:32], io_out[1][15:0]}, 0);
    do_access(1, 1'b0, 6'd61, 16'h0000, 1'b0, rd);
    check("io_rd_61", rd, 16'h00A5);

    // Requests during WAIT are ignored.
    do_access(1, 1'b1, 6'd62, 16'h7777, 1'b1, rd);
    no_ready(1, 3);
    do_access(1, 1'b0, 6'd62, 16'h0000, 1'b1, rd);
    no_ready(1, 3);
    check("ignored_rd_62", rd, 16'h7777);

    // Back-to-back at WAIT_STATES=0: one access every 2 cycles.
    t0 = cyc;
    for (int i = 0; i < 4; i++) do_access(0, 1'b1, AW'(i), DW'(i + 1), 1'b0, rd);
    for (int i = 0; i < 4; i++) begin
      do_access(0, 1'b0, AW'(i), '0, 1'b0, rd);
      check("b2b_rd", rd, i + 1);
    end
    check("b2b_cycles", cyc - t0, 16);

    // Asynchronous reset while a read of a non-zero I/O register is presented.
    do_access(1, 1'b1, 6'd62, 16'h5A5A, 1'b0, rd);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 6'd62;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_ready", ready[1], 1);
    check("pre_rst_rdata", rdata[1], 16'h5A5A);
    rst = 1'b1;
    #1;
    check("async_rst_ready", ready[1], 0);
    check("async_rst_rdata", rdata[1], 0);
    check("async_rst_busy", busy[1], 0);
    check("async_rst_io", io_out[1], 0);
    @(negedge clk);
    rst = 1'b0;
    clear_io_model();
    @(negedge clk);
    check("rel_io1", io_out[1], 0);
    check("rel_busy1", busy[1], 0);

    // Reset during WAIT abandons the write.
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 6'd60; wdata[1] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    check("midwait_busy", busy[1], 1);
    rst = 1'b1;
    no_ready(1, 3);
    rst = 1'b0;
    no_ready(1, 3);
    check("midwait_io", io_out[1], io_exp(1));
    check("midwait_reg0", io_out[1][15:0], 0);

    // Randomized accesses on both instances.
    for (int i = 0; i < 120; i++) begin
      int d;
      logic [AW-1:0] a;
      d = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(IOB, 63)) : AW'($urandom_range(0, 15));
      do_access(d, 1'($urandom), a, DW'($urandom), 1'($urandom), rd);
    end
    check("final_io0", io_out[0], io_exp(0));
    check("final_io1", io_out[1], io_exp(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
